// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the 8-bit accumulator CPU: opcode
//               values, micro-step encoding and the control strobe bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Opcodes (IR high nibble)
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Micro-step encoding
    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    // Per-cycle control word. 'halt' and 'last' steer the sequencer itself:
    // 'halt' latches the halted state, 'last' ends the instruction.
    typedef struct packed {
        logic pc_out;
        logic pc_inc;
        logic pc_load;
        logic mar_load;
        logic ir_load;
        logic ir_out;
        logic mem_rd;
        logic mem_wr;
        logic a_load;
        logic a_out;
        logic b_load;
        logic alu_out;
        logic alu_sub;
        logic flags_load;
        logic out_load;
        logic halt;
        logic last;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/cpu_microcode_rom.sv
`default_nettype none
// ============================================================================
// Module      : cpu_microcode_rom
// Description : Combinational microcode: (step, opcode, flags) -> ctrl_t.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_microcode_rom
    import cpu_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [2:0]      step,
    input  logic [OP_W-1:0] opcode,
    input  logic            carry_flag,
    input  logic            zero_flag,
    output ctrl_t           ctrl
);

    // Decode the current micro-step; unused step/opcode slots end the instruction
    always_comb begin
        ctrl = '0;
        case (step)
            T0: begin
                ctrl.pc_out   = 1'b1;
                ctrl.mar_load = 1'b1;
            end
            T1: begin
                ctrl.mem_rd  = 1'b1;
                ctrl.ir_load = 1'b1;
                ctrl.pc_inc  = 1'b1;
            end
            T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl.ir_out   = 1'b1;
                        ctrl.mar_load = 1'b1;
                    end
                    OP_LDI: begin
                        ctrl.ir_out = 1'b1;
                        ctrl.a_load = 1'b1;
                        ctrl.last   = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl.ir_out  = 1'b1;
                        ctrl.pc_load = 1'b1;
                        ctrl.last    = 1'b1;
                    end
                    OP_JC: begin
                        ctrl.ir_out  = 1'b1;
                        ctrl.pc_load = carry_flag;
                        ctrl.last    = 1'b1;
                    end
                    OP_JZ: begin
                        ctrl.ir_out  = 1'b1;
                        ctrl.pc_load = zero_flag;
                        ctrl.last    = 1'b1;
                    end
                    OP_OUT: begin
                        ctrl.a_out    = 1'b1;
                        ctrl.out_load = 1'b1;
                        ctrl.last     = 1'b1;
                    end
                    OP_HLT: begin
                        ctrl.halt = 1'b1;
                        ctrl.last = 1'b1;
                    end
                    default: ctrl.last = 1'b1;
                endcase
            end
            T3: begin
                case (opcode)
                    OP_LDA: begin
                        ctrl.mem_rd = 1'b1;
                        ctrl.a_load = 1'b1;
                        ctrl.last   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl.mem_rd = 1'b1;
                        ctrl.b_load = 1'b1;
                    end
                    OP_STA: begin
                        ctrl.a_out  = 1'b1;
                        ctrl.mem_wr = 1'b1;
                        ctrl.last   = 1'b1;
                    end
                    default: ctrl.last = 1'b1;
                endcase
            end
            T4: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    ctrl.alu_out    = 1'b1;
                    ctrl.a_load     = 1'b1;
                    ctrl.flags_load = 1'b1;
                    ctrl.alu_sub    = (opcode == OP_SUB);
                end
                ctrl.last = 1'b1;
            end
            default: ctrl.last = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_control_sequencer
// Description : Fetch/decode/execute micro-step sequencer with memory-ready
//               stall, halt latch and step-enable gating around the ROM.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_control_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int OP_W   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic [OP_W-1:0] opcode,
    input  logic            carry_flag,
    input  logic            zero_flag,
    input  logic            mem_ready,
    output logic            pc_out,
    output logic            pc_inc,
    output logic            pc_load,
    output logic            mar_load,
    output logic            ir_load,
    output logic            ir_out,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            a_load,
    output logic            a_out,
    output logic            b_load,
    output logic            alu_out,
    output logic            alu_sub,
    output logic            flags_load,
    output logic            out_load,
    output logic [2:0]      step,
    output logic            halted
);

    // The operand nibble never passes through the sequencer; a zero-width
    // operand field is not a usable configuration and elaborates nothing.
    if (ADDR_W < 1) begin : g_addr_w_unused
    end

    logic [2:0] r_step;
    logic [2:0] w_step_nxt;
    logic       r_halted;
    logic       w_halted_nxt;
    ctrl_t      w_rom;
    logic       w_stall;
    logic       w_active;
    logic       w_load_ok;

    cpu_microcode_rom #(
        .OP_W(OP_W)
    ) u_rom (
        .step       (r_step),
        .opcode     (opcode),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .ctrl       (w_rom)
    );

    // Memory steps wait for the handshake; strobes only flow when running
    assign w_stall   = (w_rom.mem_rd | w_rom.mem_wr) & ~mem_ready;
    assign w_active  = ~rst & ~r_halted & ena;
    assign w_load_ok = w_active & ~w_stall;

    assign pc_out     = w_active  & w_rom.pc_out;
    assign pc_inc     = w_load_ok & w_rom.pc_inc;
    assign pc_load    = w_active  & w_rom.pc_load;
    assign mar_load   = w_active  & w_rom.mar_load;
    assign ir_load    = w_load_ok & w_rom.ir_load;
    assign ir_out     = w_active  & w_rom.ir_out;
    assign mem_rd     = w_active  & w_rom.mem_rd;
    assign mem_wr     = w_active  & w_rom.mem_wr;
    assign a_load     = w_load_ok & w_rom.a_load;
    assign a_out      = w_active  & w_rom.a_out;
    assign b_load     = w_load_ok & w_rom.b_load;
    assign alu_out    = w_active  & w_rom.alu_out;
    assign alu_sub    = w_active  & w_rom.alu_sub;
    assign flags_load = w_active  & w_rom.flags_load;
    assign out_load   = w_active  & w_rom.out_load;

    assign step   = r_step;
    assign halted = r_halted;

    // Next step: reset > halted > enable/stall, then halt, wrap or advance
    always_comb begin
        w_step_nxt   = r_step;
        w_halted_nxt = r_halted;
        if (rst) begin
            w_step_nxt   = T0;
            w_halted_nxt = 1'b0;
        end else if (r_halted) begin
            w_step_nxt = T0;
        end else if (ena && !w_stall) begin
            if (w_rom.halt) begin
                w_step_nxt   = T0;
                w_halted_nxt = 1'b1;
            end else if (w_rom.last) begin
                w_step_nxt = T0;
            end else begin
                w_step_nxt = r_step + 3'd1;
            end
        end
    end

    // Step and halt state registers
    always_ff @(posedge clk) begin
        r_step   <= w_step_nxt;
        r_halted <= w_halted_nxt;
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_control_sequencer
// Description : Self-checking bench: directed scenarios plus random
//               instruction streams against an instruction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_control_sequencer;

    logic       clk = 1'b0;
    logic       rst, ena, carry_flag, zero_flag, mem_ready;
    logic [3:0] opcode;
    logic       pc_out, pc_inc, pc_load, mar_load, ir_load, ir_out;
    logic       mem_rd, mem_wr, a_load, a_out, b_load, alu_out, alu_sub;
    logic       flags_load, out_load, halted;
    logic [2:0] step;

    int n_tests = 0;
    int n_fail  = 0;

    // Strobe masks in bench-local order
    localparam logic [14:0] M_PC_OUT   = 15'd1 << 14;
    localparam logic [14:0] M_PC_INC   = 15'd1 << 13;
    localparam logic [14:0] M_PC_LOAD  = 15'd1 << 12;
    localparam logic [14:0] M_MAR_LOAD = 15'd1 << 11;
    localparam logic [14:0] M_IR_LOAD  = 15'd1 << 10;
    localparam logic [14:0] M_IR_OUT   = 15'd1 << 9;
    localparam logic [14:0] M_MEM_RD   = 15'd1 << 8;
    localparam logic [14:0] M_MEM_WR   = 15'd1 << 7;
    localparam logic [14:0] M_A_LOAD   = 15'd1 << 6;
    localparam logic [14:0] M_A_OUT    = 15'd1 << 5;
    localparam logic [14:0] M_B_LOAD   = 15'd1 << 4;
    localparam logic [14:0] M_ALU_OUT  = 15'd1 << 3;
    localparam logic [14:0] M_ALU_SUB  = 15'd1 << 2;
    localparam logic [14:0] M_FLAGS_LD = 15'd1 << 1;
    localparam logic [14:0] M_OUT_LOAD = 15'd1 << 0;
    localparam logic [14:0] M_LOADS    = M_IR_LOAD | M_PC_INC | M_A_LOAD | M_B_LOAD;
    localparam logic [14:0] M_NONE     = 15'd0;

    logic [14:0] obs;
    assign obs = {pc_out, pc_inc, pc_load, mar_load, ir_load, ir_out, mem_rd,
                  mem_wr, a_load, a_out, b_load, alu_out, alu_sub, flags_load,
                  out_load};

    // Model state: instruction currently applied and whether the CPU halted
    logic [3:0] cur_op;
    logic       cur_c, cur_z;
    logic       m_halted;

    cpu_control_sequencer #(.ADDR_W(4), .OP_W(4)) dut (
        .clk(clk), .rst(rst), .ena(ena), .opcode(opcode),
        .carry_flag(carry_flag), .zero_flag(zero_flag), .mem_ready(mem_ready),
        .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load),
        .mar_load(mar_load), .ir_load(ir_load), .ir_out(ir_out),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .a_load(a_load), .a_out(a_out),
        .b_load(b_load), .alu_out(alu_out), .alu_sub(alu_sub),
        .flags_load(flags_load), .out_load(out_load), .step(step),
        .halted(halted)
    );

    always #5 clk = ~clk;

    // Execute-phase micro-operation list of each instruction
    function automatic int exec_len(input logic [3:0] op);
        case (op)
            4'h1, 4'h4: return 2;
            4'h2, 4'h3: return 3;
            default:    return 1;
        endcase
    endfunction

    function automatic logic [14:0] exec_word(input logic [3:0] op, input int k,
                                              input logic c, input logic z);
        logic [14:0] addr_phase;
        addr_phase = M_IR_OUT | M_MAR_LOAD;
        case (op)
            4'h1: return (k == 0) ? addr_phase : (M_MEM_RD | M_A_LOAD);
            4'h2: return (k == 0) ? addr_phase : (k == 1) ? (M_MEM_RD | M_B_LOAD)
                         : (M_ALU_OUT | M_A_LOAD | M_FLAGS_LD);
            4'h3: return (k == 0) ? addr_phase : (k == 1) ? (M_MEM_RD | M_B_LOAD)
                         : (M_ALU_OUT | M_A_LOAD | M_FLAGS_LD | M_ALU_SUB);
            4'h4: return (k == 0) ? addr_phase : (M_A_OUT | M_MEM_WR);
            4'h5: return M_IR_OUT | M_A_LOAD;
            4'h6: return M_IR_OUT | M_PC_LOAD;
            4'h7: return M_IR_OUT | (c ? M_PC_LOAD : M_NONE);
            4'h8: return M_IR_OUT | (z ? M_PC_LOAD : M_NONE);
            4'hE: return M_A_OUT | M_OUT_LOAD;
            default: return M_NONE;
        endcase
    endfunction

    // One clock cycle: drive inputs after the falling edge, then compare
    task automatic do_cycle(input logic r, input logic e, input logic mr,
                            input logic [14:0] ev, input logic [2:0] es,
                            input string tag);
        @(negedge clk);
        rst = r; ena = e; mem_ready = mr;
        opcode = cur_op; carry_flag = cur_c; zero_flag = cur_z;
        #1;
        n_tests++;
        assert (obs === ev) else begin
            n_fail++;
            $error("FAIL %s op=%h strobes got=%b want=%b", tag, cur_op, obs, ev);
        end
        n_tests++;
        assert (step === es) else begin
            n_fail++;
            $error("FAIL %s op=%h step got=%0d want=%0d", tag, cur_op, step, es);
        end
        n_tests++;
        assert (halted === m_halted) else begin
            n_fail++;
            $error("FAIL %s op=%h halted got=%b want=%b", tag, cur_op, halted, m_halted);
        end
    endtask

    // Run one instruction. wait_k/wait_n: stall cycles at one memory step;
    // rnd: random waits at other memory steps; freeze_k/n: ena=0 cycles;
    // rst_k: assert reset during a stall at that memory step.
    task automatic run_instr(input logic [3:0] op, input logic c, input logic z,
                             input int wait_k, input int wait_n, input bit rnd,
                             input int freeze_k, input int freeze_n,
                             input int rst_k);
        int          total;
        int          nw;
        logic [14:0] w;
        cur_op = op; cur_c = c; cur_z = z;
        total = 2 + exec_len(op);
        for (int k = 0; k < total; k++) begin
            if (k == 0)      w = M_PC_OUT | M_MAR_LOAD;
            else if (k == 1) w = M_MEM_RD | M_IR_LOAD | M_PC_INC;
            else             w = exec_word(op, k - 2, c, z);
            if (k == freeze_k)
                repeat (freeze_n) do_cycle(1'b0, 1'b0, 1'($urandom), M_NONE, 3'(k), "freeze");
            if ((w & (M_MEM_RD | M_MEM_WR)) != 0) begin
                if (k == wait_k) nw = wait_n;
                else if (rnd)    nw = int'($urandom_range(0, 2));
                else             nw = 0;
                if (k == rst_k && nw == 0) nw = 1;
                repeat (nw) do_cycle(1'b0, 1'b1, 1'b0, w & ~M_LOADS, 3'(k), "stall");
                if (k == rst_k) begin
                    do_cycle(1'b1, 1'b1, 1'b0, M_NONE, 3'(k), "rst_mid");
                    m_halted = 1'b0;
                    return;
                end
                do_cycle(1'b0, 1'b1, 1'b1, w, 3'(k), "mem_step");
            end else begin
                do_cycle(1'b0, 1'b1, 1'($urandom), w, 3'(k), "exec_step");
            end
        end
        if (op == 4'hF) m_halted = 1'b1;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; mem_ready = 1'b0; opcode = 4'h0;
        carry_flag = 1'b0; zero_flag = 1'b0;
        cur_op = 4'h0; cur_c = 1'b0; cur_z = 1'b0; m_halted = 1'b0;

        // Reset state
        do_cycle(1'b1, 1'b0, 1'b0, M_NONE, 3'd0, "reset");
        do_cycle(1'b1, 1'b1, 1'b1, M_NONE, 3'd0, "reset_ena");

        // LDI 7 then OUT, zero-wait memory
        run_instr(4'h5, 1'b0, 1'b0, -1, 0, 1'b0, -1, 0, -1);
        run_instr(4'hE, 1'b0, 1'b0, -1, 0, 1'b0, -1, 0, -1);

        // ADD with two wait cycles in the T3 read
        run_instr(4'h2, 1'b0, 1'b0, 3, 2, 1'b0, -1, 0, -1);

        // JC not taken, then taken; JZ both ways
        run_instr(4'h7, 1'b0, 1'b1, -1, 0, 1'b0, -1, 0, -1);
        run_instr(4'h7, 1'b1, 1'b0, -1, 0, 1'b0, -1, 0, -1);
        run_instr(4'h8, 1'b1, 1'b0, -1, 0, 1'b0, -1, 0, -1);
        run_instr(4'h8, 1'b0, 1'b1, -1, 0, 1'b0, -1, 0, -1);

        // HLT, then ten idle cycles with mem_ready toggling, then reset
        run_instr(4'hF, 1'b0, 1'b0, -1, 0, 1'b0, -1, 0, -1);
        for (int i = 0; i < 10; i++)
            do_cycle(1'b0, 1'b1, 1'(i & 1), M_NONE, 3'd0, "halted_idle");
        do_cycle(1'b1, 1'b1, 1'b1, M_NONE, 3'd0, "rst_halt");
        m_halted = 1'b0;

        // Reset during a stalled STA write
        run_instr(4'h4, 1'b0, 1'b0, 3, 1, 1'b0, -1, 0, 3);

        // ena low for three cycles at ADD T3
        run_instr(4'h2, 1'b0, 1'b0, -1, 0, 1'b0, 3, 3, -1);

        // LDA, SUB and an undefined opcode with a fetch stall
        run_instr(4'h1, 1'b0, 1'b0, 1, 1, 1'b0, -1, 0, -1);
        run_instr(4'h3, 1'b1, 1'b1, 4, 0, 1'b1, -1, 0, -1);
        run_instr(4'hB, 1'b0, 1'b0, -1, 0, 1'b1, -1, 0, -1);

        // Random instruction stream
        for (int n = 0; n < 300; n++) begin
            logic [3:0] op;
            int         fk;
            op = 4'($urandom_range(0, 15));
            fk = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(op, 1'($urandom), 1'($urandom), -1, 0, 1'b1, fk,
                      int'($urandom_range(1, 3)), -1);
            if (m_halted) begin
                do_cycle(1'b0, 1'b1, 1'($urandom), M_NONE, 3'd0, "rand_halted");
                do_cycle(1'b0, 1'b0, 1'($urandom), M_NONE, 3'd0, "rand_halted_off");
                do_cycle(1'b1, 1'b1, 1'b0, M_NONE, 3'd0, "rand_rst");
                m_halted = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
